pipeline_drain_ctrl: RTL and testbench

Stage-enable sequencer that both fills and drains the 5-stage MIPS pipeline on request. It gates fetch and shifts a per-stage valid token down the pipeline. On a halt request it stops fetch and lets in-flight instructions retire stage by stage before reporting `halted`. It sits beside the pipeline registers, consumes halt/resume/stall/flush from the debug/hazard logic, and drives the IF/ID … MEM/WB enable lines.

---
 rtl/pipeline_drain_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_drain_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_drain_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pipeline_drain_ctrl
//
// Stage-enable sequencer for the 5-stage MIPS pipeline. It gates fetch and
// shifts a per-stage valid token down the pipeline. This lets the pipeline
// fill from a halted state and drain in-flight instructions on a halt
// request before reporting halted.
//
// Parameters:
//   STAGES        number of inter-stage registers driven (legal 2..16)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   halt_req      level: stop fetch and drain the pipeline
//   resume_req    level: restart from HALTED
//   stall         hazard stall, freezes the valid-token shift
//   flush         kill all in-flight instructions
//   fetch_ena     PC/fetch advance enable (FILL or RUN)
//   stage_ena     bit i enables inter-stage register i (bit 0 = IF/ID)
//   draining      high while in DRAIN
//   halted        high while in HALTED
//   drain_cycles  (PIPELINE_DRAIN_CNT_EN only) saturating count of cycles
//                 spent in the most recent DRAIN, stalls included
//
// Optional feature macro: PIPELINE_DRAIN_CNT_EN
// ---------------------------------------------------------------------------
module pipeline_drain_ctrl #(
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              stall,
  input  logic              flush,
  output logic              fetch_ena,
  output logic [STAGES-1:0] stage_ena,
  output logic              draining,
  output logic              halted
`ifdef PIPELINE_DRAIN_CNT_EN
  ,
  output logic [7:0]        drain_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [STAGES-1:0] v_reg, v_next, v_shift;
  logic              fetch_ena_reg, draining_reg, halted_reg;
  logic              low_full, low_empty;

  // Token shift: a new token enters stage 0 whenever fetch is enabled.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_shift
      if (gi == 0) begin : g_head
        assign v_shift[gi] = fetch_ena_reg;
      end else begin : g_body
        assign v_shift[gi] = v_reg[gi-1];
      end
    end
  endgenerate

  // Looking at the lower STAGES-1 bits tells us what the shift will produce
  // in the top STAGES-1 bits; fill completes / drain empties on this shift.
  assign low_full  = &v_reg[STAGES-2:0];
  assign low_empty = ~|v_reg[STAGES-2:0];

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      unique case (state_reg)
        ST_FILL, ST_RUN: state_next = halt_req ? ST_HALTED : ST_FILL;
        ST_DRAIN:        state_next = ST_HALTED;
        default:         state_next = ST_HALTED;
      endcase
    end else begin
      unique case (state_reg)
        ST_HALTED: if (resume_req && !halt_req) state_next = ST_FILL;
        ST_FILL: begin
          if (halt_req)               state_next = ST_DRAIN;
          else if (!stall && low_full) state_next = ST_RUN;
        end
        ST_RUN:    if (halt_req) state_next = ST_DRAIN;
        // resume_req is deliberately ignored here; it must be reissued
        // once HALTED is reached.
        ST_DRAIN:  if (!stall && low_empty) state_next = ST_HALTED;
        default:   state_next = ST_HALTED;
      endcase
    end
  end

  always_comb begin
    v_next = v_reg;
    if (flush)       v_next = '0;
    else if (!stall) v_next = v_shift;
  end

  // Outputs are registered from the next state so they line up exactly
  // with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_HALTED;
      v_reg         <= '0;
      fetch_ena_reg <= 1'b0;
      draining_reg  <= 1'b0;
      halted_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      v_reg         <= v_next;
      fetch_ena_reg <= (state_next == ST_FILL) || (state_next == ST_RUN);
      draining_reg  <= (state_next == ST_DRAIN);
      halted_reg    <= (state_next == ST_HALTED);
    end
  end

  assign fetch_ena = fetch_ena_reg;
  assign stage_ena = v_reg;
  assign draining  = draining_reg;
  assign halted    = halted_reg;

`ifdef PIPELINE_DRAIN_CNT_EN
  logic [7:0] drain_cnt_reg;

  // Cleared on the edge that enters DRAIN, then counts every edge taken
  // while in DRAIN (stalled or not), saturating at 255. Holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt_reg <= 8'd0;
    end else if (state_next == ST_DRAIN && state_reg != ST_DRAIN) begin
      drain_cnt_reg <= 8'd0;
    end else if (state_reg == ST_DRAIN && drain_cnt_reg != 8'hFF) begin
      drain_cnt_reg <= drain_cnt_reg + 8'd1;
    end
  end

  assign drain_cycles = drain_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_drain_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pipeline_drain_ctrl: directed test-plan steps
// followed by random stimulus, all compared against an instruction-token
// reference model.
module tb_pipeline_drain_ctrl;

  localparam int STAGES = 4;
  localparam int M_HALT  = 0;
  localparam int M_FILL  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              halt_req = 1'b0;
  logic              resume_req = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              fetch_ena;
  logic [STAGES-1:0] stage_ena;
  logic              draining;
  logic              halted;
`ifdef PIPELINE_DRAIN_CNT_EN
  logic [7:0]        drain_cycles;
`endif

  pipeline_drain_ctrl #(.STAGES(STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt_req   (halt_req),
    .resume_req (resume_req),
    .stall      (stall),
    .flush      (flush),
    .fetch_ena  (fetch_ena),
    .stage_ena  (stage_ena),
    .draining   (draining),
    .halted     (halted)
`ifdef PIPELINE_DRAIN_CNT_EN
    ,
    .drain_cycles (drain_cycles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pipeline mode plus which stages hold an instruction.
  int m_mode;
  bit m_tok[STAGES];
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tok_vec();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < STAGES; i++) r[i] = m_tok[i];
    return r;
  endfunction

  task automatic model_reset();
    m_mode = M_HALT;
    for (int i = 0; i < STAGES; i++) m_tok[i] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input bit h, input bit r, input bit s, input bit f);
    bit fetching, all1, all0;
    bit nt[STAGES];
    int old;
    old = m_mode;
    fetching = (old == M_FILL) || (old == M_RUN);
    // instructions advance one stage; a fetched one enters stage 0
    for (int i = 0; i < STAGES; i++) begin
      if (f)           nt[i] = 1'b0;
      else if (s)      nt[i] = m_tok[i];
      else if (i == 0) nt[i] = fetching;
      else             nt[i] = m_tok[i-1];
    end
    all1 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      if (nt[i]) all0 = 1'b0;
      else       all1 = 1'b0;
    end
    if (f) begin
      if (old == M_DRAIN)     m_mode = M_HALT;
      else if (old != M_HALT) m_mode = h ? M_HALT : M_FILL;
    end else begin
      case (old)
        M_HALT:  if (r && !h) m_mode = M_FILL;
        M_FILL:  if (h) m_mode = M_DRAIN; else if (!s && all1) m_mode = M_RUN;
        M_RUN:   if (h) m_mode = M_DRAIN;
        default: if (!s && all0) m_mode = M_HALT;
      endcase
    end
    if (old == M_DRAIN && m_cnt < 255) m_cnt++;
    if (m_mode == M_DRAIN && old != M_DRAIN) m_cnt = 0;
    m_tok = nt;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/fetch"}, 32'(fetch_ena), 32'(m_mode == M_FILL || m_mode == M_RUN));
    chk({tag, "/stage"}, 32'(stage_ena), tok_vec());
    chk({tag, "/drain"}, 32'(draining), 32'(m_mode == M_DRAIN));
    chk({tag, "/halt"},  32'(halted), 32'(m_mode == M_HALT));
`ifdef PIPELINE_DRAIN_CNT_EN
    chk({tag, "/cnt"},   32'(drain_cycles), 32'(m_cnt));
`endif
  endtask

  // One clock: drive inputs, take the edge, advance the model, check #1 later.
  task automatic step(input bit h, input bit r, input bit s, input bit f, input string tag);
    halt_req   = h;
    resume_req = r;
    stall      = s;
    flush      = f;
    @(posedge clk);
    model_edge(h, r, s, f);
    #1;
    check_model(tag);
  endtask

  task automatic fill_up();
    step(0, 1, 0, 0, "resume");
    for (int i = 0; i < STAGES; i++) step(0, 0, 0, 0, "fill");
  endtask

  logic [3:0] fill_pat[4]  = '{4'h1, 4'h3, 4'h7, 4'hF};
  logic [3:0] drain_pat[4] = '{4'hE, 4'hC, 4'h8, 4'h0};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset_halted", 32'(halted), 32'd1);
    chk("reset_stage", 32'(stage_ena), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // fill from halted
    step(0, 1, 0, 0, "resume");
    chk("resume_fetch", 32'(fetch_ena), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, "fill");
      chk("fill_pat", 32'(stage_ena), 32'(fill_pat[i]));
    end

    // plain drain
    step(1, 0, 0, 0, "halt");
    chk("halt_draining", 32'(draining), 32'd1);
    chk("halt_fetch", 32'(fetch_ena), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, "drain");
      chk("drain_pat", 32'(stage_ena), 32'(drain_pat[i]));
    end
    chk("drain_halted", 32'(halted), 32'd1);
`ifdef PIPELINE_DRAIN_CNT_EN
    chk("drain_cnt4", 32'(drain_cycles), 32'd4);
`endif

    // drain with two stall cycles after the first shift
    fill_up();
    step(1, 0, 0, 0, "halt2");
    step(0, 0, 0, 0, "drain2");
    step(0, 0, 1, 0, "stall_a");
    chk("stall_hold_a", 32'(stage_ena), 32'hE);
    step(0, 0, 1, 0, "stall_b");
    chk("stall_hold_b", 32'(stage_ena), 32'hE);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "drain2");
    chk("stall_halted", 32'(halted), 32'd1);
`ifdef PIPELINE_DRAIN_CNT_EN
    chk("drain_cnt6", 32'(drain_cycles), 32'd6);
`endif

    // flush during RUN, refill, then flush together with halt
    fill_up();
    step(0, 0, 0, 1, "flush");
    chk("flush_stage", 32'(stage_ena), 32'd0);
    chk("flush_fill", 32'(fetch_ena), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, "refill");
    chk("refill_full", 32'(stage_ena), 32'hF);
    step(1, 0, 0, 1, "flush_halt");
    chk("flush_halt_halted", 32'(halted), 32'd1);

    // halt+resume in HALTED stays halted
    step(1, 1, 0, 0, "both");
    chk("both_halted", 32'(halted), 32'd1);

    // resume during drain is ignored
    fill_up();
    step(1, 0, 0, 0, "halt3");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "drain_resume");
    chk("drain_resume_draining", 32'(draining), 32'd1);
    step(0, 1, 0, 0, "drain_resume");
    chk("drain_resume_halted", 32'(halted), 32'd1);
    step(0, 0, 0, 0, "idle");

    // asynchronous reset mid-fill
    step(0, 1, 0, 0, "resume4");
    step(0, 0, 0, 0, "fill4");
    step(0, 0, 0, 0, "fill4");
    chk("midfill_stage", 32'(stage_ena), 32'h3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_stage", 32'(stage_ena), 32'd0);
    chk("async_fetch", 32'(fetch_ena), 32'd0);
    chk("async_halted", 32'(halted), 32'd1);
    chk("async_draining", 32'(draining), 32'd0);
`ifdef PIPELINE_DRAIN_CNT_EN
    chk("async_cnt", 32'(drain_cycles), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // random phase
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 5, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
